// File: rtl/uart_fifo_v2_if.sv
// Handshake bundle between the UART FIFO and its producer/consumer.
// high_water exists only when FIFO_HIGH_WATER_EN is defined.
interface uart_fifo_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [AW:0]           af_thresh;
    logic [AW:0]           ae_thresh;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           data_count;
    logic [AW:0]           free_count;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;
`ifdef FIFO_HIGH_WATER_EN
    logic [AW:0]           high_water;
`endif

    modport master (
        output flush, wr_en, wr_data, rd_en,
        output af_thresh, ae_thresh, err_clr,
`ifdef FIFO_HIGH_WATER_EN
        input  high_water,
`endif
        input  rd_data, full, empty,
        input  almost_full, almost_empty,
        input  data_count, free_count,
        input  wr_ack, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        input  af_thresh, ae_thresh, err_clr,
`ifdef FIFO_HIGH_WATER_EN
        output high_water,
`endif
        output rd_data, full, empty,
        output almost_full, almost_empty,
        output data_count, free_count,
        output wr_ack, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_v2.sv
// Show-ahead synchronous FIFO for the UART RX/TX path.
// Optional high-water monitor: define FIFO_HIGH_WATER_EN.
module uart_fifo_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    uart_fifo_v2_if.slave bus
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count;
    logic        empty, full;
    logic        rd_acc, wr_acc;
    logic        wr_ack_q;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    // Wrap bit in the MSB distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                 & (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign rd_acc = bus.rd_en & ~empty & ~bus.flush;
    assign wr_acc = bus.wr_en & ~bus.flush & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
        end
        // A fresh error outranks a simultaneous clear.
        ovf_d = (ovf_q & ~bus.err_clr)
              | (bus.wr_en & ~bus.flush & ~wr_acc);
        udf_d = (udf_q & ~bus.err_clr)
              | (bus.rd_en & ~bus.flush & ~rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ack_q <= wr_acc;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end

    assign bus.rd_data      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.data_count   = count;
    assign bus.free_count   = DEPTH - count;
    assign bus.almost_full  = (count >= bus.af_thresh);
    assign bus.almost_empty = (count <= bus.ae_thresh);
    assign bus.wr_ack       = wr_ack_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

`ifdef FIFO_HIGH_WATER_EN
    logic [AW:0] hw_q, hw_d;

    // Tracks the registered count, so it trails a rise by one edge.
    always_comb begin
        hw_d = hw_q;
        if (bus.err_clr)      hw_d = count;
        else if (count > hw_q) hw_d = count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hw_q <= '0;
        else        hw_q <= hw_d;
    end

    assign bus.high_water = hw_q;
`endif
endmodule
